// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32-entry register file with one write port and two registered read ports.
//   R0 is hard-wired to zero: writes to it are discarded and reads return 0.
//   A write is steered by the global strobe WE and a one-hot (or multi-hot)
//   select vector WEd coming from an external address decoder.
//
//   Read data is registered, so Dout1/Dout2 show R[Ard1]/R[Ard2] one cycle
//   after the address is presented.
//
//   Build option:
//     RF_BYPASS_EN  defined   -> write-first: a read of a register being
//                                written in the same cycle returns Din.
//                   undefined -> read-first: the same read returns the value
//                                held before the write.
//
//   Ports:
//     Clk    in   1       sole clock, rising edge
//     Rst    in   1       synchronous active-high reset (clears R0..R31, Dout*)
//     WE     in   1       global write strobe
//     WEd    in   32      per-register write select, bit i -> register i
//     Din    in   DATA_W  write data
//     Ard1   in   5       read address, port 1
//     Ard2   in   5       read address, port 2
//     Dout1  out  DATA_W  registered read data, port 1
//     Dout2  out  DATA_W  registered read data, port 2
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WE,
    input  logic [31:0]       WEd,
    input  logic [DATA_W-1:0] Din,
    input  logic [4:0]        Ard1,
    input  logic [4:0]        Ard2,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [31:0]       wr_en_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // Effective per-register write enables; bit 0 is masked so R0 never loads.
    always_comb begin
        wr_en_s = 32'h0000_0000;
        if (WE) begin
            wr_en_s = WEd & 32'hFFFF_FFFE;
        end else begin
            wr_en_s = 32'h0000_0000;
        end
    end

    // Port 1 read mux: address 0 forces zero, optional same-cycle forwarding.
    always_comb begin
        rd1_s = regs_r[Ard1];
        if (Ard1 == 5'd0) begin
            rd1_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
        end else if (wr_en_s[Ard1]) begin
            rd1_s = Din;
`endif
        end else begin
            rd1_s = regs_r[Ard1];
        end
    end

    // Port 2 read mux: same rules as port 1, fully independent.
    always_comb begin
        rd2_s = regs_r[Ard2];
        if (Ard2 == 5'd0) begin
            rd2_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
        end else if (wr_en_s[Ard2]) begin
            rd2_s = Din;
`endif
        end else begin
            rd2_s = regs_r[Ard2];
        end
    end

    // Storage and output registers; reset wins over any write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            Dout1 <= {DATA_W{1'b0}};
            Dout2 <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= Din;
                end
            end
            Dout1 <= rd1_s;
            Dout2 <= rd2_s;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Scoreboard bench for register_file. The driver applies one input vector
//   per cycle, pushes the expected Dout1/Dout2 for that edge into a queue and
//   advances a behavioural array model. A separate monitor pops one entry per
//   rising edge and compares it with the DUT outputs sampled 2 time units later.
//   Directed scenarios use hand-written expected constants; random traffic
//   uses the array model.
// -----------------------------------------------------------------------------
module tb_register_file;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        string       tag;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        WE;
    logic [31:0] WEd;
    logic [31:0] Din;
    logic [4:0]  Ard1;
    logic [4:0]  Ard2;
    logic [31:0] Dout1;
    logic [31:0] Dout2;

    exp_t        sb_q[$];
    logic [31:0] mem [32];
    int          n_cmp;
    int          n_bad;
    bit          bypass;

    register_file #(.DATA_W(32), .NREGS(32)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .WE    (WE),
        .WEd   (WEd),
        .Din   (Din),
        .Ard1  (Ard1),
        .Ard2  (Ard2),
        .Dout1 (Dout1),
        .Dout2 (Dout2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model read: what a port returns for address a given this cycle's inputs.
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic rst,
                                               input logic we, input logic [31:0] wed,
                                               input logic [31:0] din);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (we && wed[a] && bypass) return din;
        return mem[a];
    endfunction

    // One clock of stimulus. If use_c, the spec constants c1/c2 are the
    // expected outputs; otherwise the array model supplies them.
    task automatic step(input logic rst, input logic we, input logic [31:0] wed,
                        input logic [31:0] din, input logic [4:0] a1, input logic [4:0] a2,
                        input bit use_c, input logic [31:0] c1, input logic [31:0] c2,
                        input string tag);
        exp_t e;
        Rst = rst; WE = we; WEd = wed; Din = din; Ard1 = a1; Ard2 = a2;
        e.tag = tag;
        if (use_c) begin
            e.d1 = c1;
            e.d2 = c2;
        end else begin
            e.d1 = model_read(a1, rst, we, wed, din);
            e.d2 = model_read(a2, rst, we, wed, din);
        end
        @(posedge Clk);
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (we) begin
            for (int i = 1; i < 32; i++) if (wed[i]) mem[i] = din;
        end
        @(negedge Clk);
    endtask

    // Monitor: one output pair per rising edge, sampled away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (Dout1 !== e.d1) begin
                    n_bad++;
                    $display("FAIL %s Dout1: got %h expected %h", e.tag, Dout1, e.d1);
                end
                n_cmp++;
                if (Dout2 !== e.d2) begin
                    n_bad++;
                    $display("FAIL %s Dout2: got %h expected %h", e.tag, Dout2, e.d2);
                end
            end
        end
    end

    initial begin
        logic [31:0] wed;
        logic [31:0] din;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  k;
        logic        rst;
        int          guard;

        n_cmp = 0;
        n_bad = 0;
`ifdef RF_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        Rst = 1'b1; WE = 1'b0; WEd = 32'h0; Din = 32'h0; Ard1 = 5'd0; Ard2 = 5'd0;

        // Reset for two cycles, then read 5 and 31
        step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "reset0");
        step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "reset1");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd31, 1'b1, 32'h0, 32'h0, "post_reset_rd");

        // Write R5 then read it
        step(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "wr_r5");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, "rd_r5");

        // R0 guard: write attempt, then read on both ports (also same cycle)
        step(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "r0_wr");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "r0_rd");

        // Collision on R7
        step(1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "r7_init");
        step(1'b0, 1'b1, 32'h0000_0080, 32'h2222_2222, 5'd7, 5'd0, 1'b1,
             bypass ? 32'h2222_2222 : 32'h1111_1111, 32'h0, "collide");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b1, 32'h2222_2222, 32'h2222_2222, "after_collide");

        // WE=1 with WEd=0 changes nothing
        step(1'b0, 1'b1, 32'h0, 32'h3333_3333, 5'd7, 5'd5, 1'b1, 32'h2222_2222, 32'hDEAD_BEEF, "wed_zero");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd5, 1'b1, 32'h2222_2222, 32'hDEAD_BEEF, "wed_zero_rd");

        // WE=0 with WEd set changes nothing
        step(1'b0, 1'b0, 32'h0000_0080, 32'h4444_4444, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "we_zero");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd0, 1'b1, 32'h2222_2222, 32'h0, "we_zero_rd");

        // Multi-hot write hits R3 and R9 (and R0, discarded)
        step(1'b0, 1'b1, 32'h0000_0209, 32'h5A5A_5A5A, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "multi_wr");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd9, 1'b1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, "multi_rd");

        // Reset priority over write to R31; earlier contents gone
        step(1'b1, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "rst_prio");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd31, 1'b1, 32'h0, 32'h0, "rst_prio_rd");
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd3, 1'b1, 32'h0, 32'h0, "rst_clears");

        // Sweep: write R1..R31, then read pairs (i, 31-i)
        for (int i = 1; i < 32; i++) begin
            din = 32'h0101_0101 * i;
            wed = 32'h1 << i;
            step(1'b0, 1'b1, wed, din, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            a1 = i[4:0];
            a2 = 5'(31 - i);
            step(1'b0, 1'b0, 32'h0, 32'h0, a1, a2, 1'b1,
                 32'h0101_0101 * i, 32'h0101_0101 * (31 - i), "sweep_rd");
        end

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            k = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: wed = 32'h0;
                1: wed = 32'h1 << k;
                2: wed = $urandom;
                default: wed = (32'h1 << k) | (32'h1 << $urandom_range(0, 31));
            endcase
            din = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? k : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? k : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a2 = a1;
            rst = ($urandom_range(0, 59) == 0);
            step(rst, 1'($urandom_range(0, 1)), wed, din, a1, a2, 1'b0, 32'h0, 32'h0, "random");
        end

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
